// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between instruction fetch and the MEM stage, with a
// wait-state sequencer, registered read data/acks and the pipeline stall vector.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_ce,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic [5:0]        stall
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_ACC  = 2'd1,
    ST_MEM_ACC = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES);

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                last_mem_r;
  logic                if_elig_s, mem_elig_s;
  logic                grant_if_s, grant_mem_s, done_s;
  logic                if_ack_r, mem_ack_r;
  logic [DATA_W-1:0]   if_rdata_r, mem_rdata_r;
  logic                bus_ce_r, bus_we_r;
  logic [3:0]          bus_sel_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_wdata_r;
  logic [5:0]          stall_s;

  // Grant arbitration and access completion; a requester is ignored in its own ack cycle.
  always_comb begin
    state_next_s = state_r;
    grant_if_s   = 1'b0;
    grant_mem_s  = 1'b0;
    done_s       = 1'b0;
    if_elig_s    = if_req & ~if_ack_r;
    mem_elig_s   = mem_req & ~mem_ack_r;
    case (state_r)
      ST_IDLE: begin
        if (if_elig_s && mem_elig_s) begin
          if (last_mem_r) begin
            grant_if_s = 1'b1;
          end else begin
            grant_mem_s = 1'b1;
          end
        end else if (if_elig_s) begin
          grant_if_s = 1'b1;
        end else if (mem_elig_s) begin
          grant_mem_s = 1'b1;
        end else begin
          grant_if_s = 1'b0;
        end
        if (grant_mem_s) begin
          state_next_s = ST_MEM_ACC;
        end else if (grant_if_s) begin
          state_next_s = ST_IF_ACC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_IF_ACC, ST_MEM_ACC: begin
        if ((cnt_r == LAST_CNT) && bus_ready) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait-state counter saturates at WAIT_STATES; last_mem remembers who finished last.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      last_mem_r <= 1'b0;
    end else begin
      if (grant_if_s || grant_mem_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r != ST_IDLE) && (cnt_r != LAST_CNT)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (done_s) begin
        last_mem_r <= (state_r == ST_MEM_ACC);
      end else begin
        last_mem_r <= last_mem_r;
      end
    end
  end

  // Bus request registers, latched at grant so they stay stable through the access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_ce_r    <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'b0000;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
    end else if (grant_if_s) begin
      bus_ce_r    <= 1'b1;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'b1111;
      bus_addr_r  <= if_addr;
      bus_wdata_r <= {DATA_W{1'b0}};
    end else if (grant_mem_s) begin
      bus_ce_r    <= 1'b1;
      bus_we_r    <= mem_we;
      bus_sel_r   <= mem_sel;
      bus_addr_r  <= mem_addr;
      bus_wdata_r <= mem_wdata;
    end else if (done_s) begin
      bus_ce_r <= 1'b0;
      bus_we_r <= 1'b0;
    end else begin
      bus_ce_r <= bus_ce_r;
    end
  end

  // One-cycle acks and registered read data of the granted requester.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if_ack_r  <= done_s && (state_r == ST_IF_ACC);
      mem_ack_r <= done_s && (state_r == ST_MEM_ACC);
      if (done_s && (state_r == ST_IF_ACC)) begin
        if_rdata_r <= bus_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (done_s && (state_r == ST_MEM_ACC) && !bus_we_r) begin
        mem_rdata_r <= bus_rdata;
      end else begin
        mem_rdata_r <= mem_rdata_r;
      end
    end
  end

  // Stall vector follows the raw requests so the pipeline freezes in the request cycle.
  always_comb begin
    stall_s = 6'b000000;
    if (!reset) begin
      stall_s = 6'b000000;
    end else if (mem_req && !mem_ack_r) begin
      stall_s = 6'b011111;
    end else if (if_req && !if_ack_r) begin
      stall_s = 6'b000011;
    end else begin
      stall_s = 6'b000000;
    end
  end

  assign if_ack    = if_ack_r;
  assign mem_ack   = mem_ack_r;
  assign if_rdata  = if_rdata_r;
  assign mem_rdata = mem_rdata_r;
  assign bus_ce    = bus_ce_r;
  assign bus_we    = bus_we_r;
  assign bus_sel   = bus_sel_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign stall     = stall_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single accesses,
// hand-written arbitration/reset sequences, and an ack scoreboard.
module tb_mem_port_arbiter;
  localparam int WS = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we, bus_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ack, mem_ack, bus_ce, bus_we;
  logic [3:0]  bus_sel;
  logic [5:0]  stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } vec_t;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic exp_ce, input logic [31:0] exp_addr,
                             input logic exp_we, input logic [3:0] exp_sel,
                             input logic [31:0] exp_wdata, input logic chk_wdata,
                             input logic exp_if_ack, input logic exp_mem_ack);
    logic [5:0] exp_stall;
    exp_stall = (mem_req && !exp_mem_ack) ? 6'b011111 :
                (if_req && !exp_if_ack)   ? 6'b000011 : 6'b000000;
    check({tag, " stall"},   32'(stall),   32'(exp_stall));
    check({tag, " bus_ce"},  32'(bus_ce),  32'(exp_ce));
    check({tag, " if_ack"},  32'(if_ack),  32'(exp_if_ack));
    check({tag, " mem_ack"}, 32'(mem_ack), 32'(exp_mem_ack));
    if (exp_ce) begin
      check({tag, " bus_addr"}, bus_addr,       exp_addr);
      check({tag, " bus_we"},   32'(bus_we),    32'(exp_we));
      check({tag, " bus_sel"},  32'(bus_sel),   32'(exp_sel));
      if (chk_wdata) check({tag, " bus_wdata"}, bus_wdata, exp_wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"},     32'(stall),   32'd0);
    check({tag, " bus_ce"},    32'(bus_ce),  32'd0);
    check({tag, " bus_we"},    32'(bus_we),  32'd0);
    check({tag, " bus_sel"},   32'(bus_sel), 32'd0);
    check({tag, " bus_addr"},  bus_addr,     32'd0);
    check({tag, " bus_wdata"}, bus_wdata,    32'd0);
    check({tag, " if_ack"},    32'(if_ack),  32'd0);
    check({tag, " mem_ack"},   32'(mem_ack), 32'd0);
    check({tag, " if_rdata"},  if_rdata,     32'd0);
    check({tag, " mem_rdata"}, mem_rdata,    32'd0);
  endtask

  // Single access; called just after a rising edge (cycle k=0 = request cycle).
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   last_k;
    last_k   = 1 + WS + v.delay;
    e.is_mem = v.is_mem;
    e.rdata  = (v.is_mem && v.we) ? mem_model : v.rdata;
    if (v.is_mem && !v.we) mem_model = v.rdata;
    sb_q.push_back(e);
    for (int k = 0; k <= last_k + 2; k++) begin
      if_req    = !v.is_mem && (k <= last_k + 1);
      mem_req   = v.is_mem && (k <= last_k + 1);
      if_addr   = v.addr;
      mem_addr  = v.addr;
      mem_we    = v.we;
      mem_sel   = v.sel;
      mem_wdata = v.wdata;
      bus_rdata = v.rdata;
      bus_ready = (k <= WS) || (k == last_k);
      @(negedge clock);
      check_cycle($sformatf("vec%0d k%0d", idx, k), (k >= 1) && (k <= last_k), v.addr,
                  v.is_mem ? v.we : 1'b0, v.is_mem ? v.sel : 4'hF, v.wdata, v.is_mem,
                  !v.is_mem && (k == last_k + 1), v.is_mem && (k == last_k + 1));
      @(posedge clock); #1;
    end
  endtask

  // Both requesters rise together; the loser is granted in the winner's ack cycle.
  task automatic run_pair(input logic first_mem);
    exp_t        e;
    logic [31:0] a, b;
    logic        cur_mem;
    a = 32'h1111_2222;
    b = 32'h3333_4444;
    if_addr = 32'h0000_0400; mem_addr = 32'h0000_0500;
    mem_we = 1'b0; mem_sel = 4'hF; mem_wdata = 32'h0;
    e.is_mem = first_mem;  e.rdata = a; sb_q.push_back(e);
    e.is_mem = !first_mem; e.rdata = b; sb_q.push_back(e);
    mem_model = first_mem ? a : b;
    for (int k = 0; k <= 7; k++) begin
      mem_req   = first_mem ? (k <= 3) : (k <= 6);
      if_req    = first_mem ? (k <= 6) : (k <= 3);
      bus_ready = 1'b1;
      bus_rdata = (k < 3) ? a : b;
      cur_mem   = (k < 3) ? first_mem : !first_mem;
      @(negedge clock);
      check_cycle($sformatf("pair%0b k%0d", first_mem, k),
                  (k == 1) || (k == 2) || (k == 4) || (k == 5),
                  cur_mem ? 32'h0000_0500 : 32'h0000_0400, 1'b0, 4'hF, 32'h0, 1'b0,
                  ((k == 3) && !first_mem) || ((k == 6) && first_mem),
                  ((k == 3) && first_mem) || ((k == 6) && !first_mem));
      @(posedge clock); #1;
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding access.
  always @(negedge clock) begin
    if (reset && (if_ack || mem_ack)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected ack: if_ack=%0b mem_ack=%0b with none outstanding", if_ack, mem_ack);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack kind", {30'd0, if_ack, mem_ack}, {30'd0, !e.is_mem, e.is_mem});
        check("ack rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
      end
    end
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'hF,    32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0};
    vecs[1] = '{1'b1, 1'b0, 4'hF,    32'h0000_0204, 32'h0,          32'hCAFE_F00D, 0};
    vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678,  32'hBAD0_BAD0, 0};
    vecs[3] = '{1'b0, 1'b0, 4'hF,    32'h0000_0104, 32'h0,          32'h0BAD_C0DE, 5};
    vecs[4] = '{1'b1, 1'b1, 4'b1100, 32'h0000_0300, 32'hA5A5_5A5A,  32'h7777_7777, 2};
    vecs[5] = '{1'b0, 1'b0, 4'hF,    32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 0};
    vecs[6] = '{1'b1, 1'b0, 4'hF,    32'h0000_0308, 32'h0,          32'h55AA_33CC, 1};

    reset = 1'b0; mem_model = 32'h0;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'h0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_rdata = 32'h0; bus_ready = 1'b1;
    #12;
    check_all_zero("reset");
    if_req = 1'b0; mem_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    run_pair(1'b1);
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
    run_pair(1'b0);

    // Reset in the first cycle of a MEM access: everything drops at once, no ack.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0600; mem_sel = 4'hF; bus_ready = 1'b1;
    @(posedge clock); #1;
    check("pre-reset bus_ce", 32'(bus_ce), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("mid-access reset");
    mem_model = 32'h0;
    mem_req = 1'b0; if_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    run_vec(7, '{1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 32'h7654_3210, 0});

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
